// File: rtl/stage1_if_prefetch_pkg.sv
// Shared widths and bus layouts for the IF prefetch stage.
// br_bus is {cancel, taken, target}; fs_to_ds_bus is {inst, pc}.
package stage1_if_prefetch_pkg;

  localparam int         WIDTH_BR_BUS       = 34;
  localparam int         WIDTH_FS_TO_DS_BUS = 64;
  localparam logic [1:0] INST_SIZE_WORD     = 2'b10;

  typedef struct packed {
    logic        cancel;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/stage1_if_prefetch_fifo.sv
// Synchronous FIFO with flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stage1_if_prefetch.sv
// IF stage: pipelined fetches on the req/addr_ok/data_ok bus into an instruction queue,
// with branch redirect, queue flush and discard of stale in-flight responses.
module stage1_if_prefetch
  import stage1_if_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h1C000000,
  parameter int          BUF_DEPTH       = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ds_allow_in,
  input  logic [WIDTH_BR_BUS-1:0]       br_bus,
  output logic                          fs_to_ds_valid,
  output logic [WIDTH_FS_TO_DS_BUS-1:0] fs_to_ds_bus,
  output logic                          inst_sram_req,
  output logic                          inst_sram_wr,
  output logic [1:0]                    inst_sram_size,
  output logic [3:0]                    inst_sram_wstrb,
  output logic [31:0]                   inst_sram_addr,
  output logic [31:0]                   inst_sram_wdata,
  input  logic                          inst_sram_addr_ok,
  input  logic                          inst_sram_data_ok,
  input  logic [31:0]                   inst_sram_rdata
);

  localparam int QCW = $clog2(BUF_DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = QCW + 1;

  br_bus_t       br;
  logic          redirect;
  logic [31:0]   fetch_pc, pend_pc, tag_pc;
  logic          pend_vld, req_held;
  logic [CW-1:0] outstanding, outstanding_nxt, discard_cnt;
  logic          accept, credit, held_now, q_push, q_pop;
  logic [QCW-1:0] q_count;
  logic          q_full, q_empty;
  logic [TCW-1:0] tag_count;
  logic          tag_full, tag_empty;
  fs_to_ds_t     q_din, q_dout;
  logic          unused_fifo_flags;

  assign br       = br_bus;
  assign redirect = br.taken | br.cancel;

  // Credit counts in-flight words against queue space so every response has a slot.
  assign credit = (outstanding < CW'(MAX_OUTSTANDING)) &&
                  ((CW'(q_count) + outstanding) < CW'(BUF_DEPTH));

  assign inst_sram_req   = !reset && (req_held || credit);
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = INST_SIZE_WORD;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign accept          = inst_sram_req && inst_sram_addr_ok;
  assign held_now        = inst_sram_req && !inst_sram_addr_ok;
  assign outstanding_nxt = outstanding + CW'(accept) - CW'(inst_sram_data_ok);

  assign q_push         = inst_sram_data_ok && (discard_cnt == '0) && !redirect;
  assign fs_to_ds_valid = !q_empty && !br.taken;
  assign q_pop          = fs_to_ds_valid && ds_allow_in;
  assign q_din          = '{inst: inst_sram_rdata, pc: tag_pc};
  assign fs_to_ds_bus   = q_dout;

  assign unused_fifo_flags = q_full ^ tag_full ^ tag_empty ^ (^tag_count);

  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING), .CW(TCW)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (inst_sram_data_ok),
    .flush (1'b0),
    .din   (inst_sram_addr),
    .dout  (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  sync_fifo #(.WIDTH(WIDTH_FS_TO_DS_BUS), .DEPTH(BUF_DEPTH), .CW(QCW)) u_inst_q (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      pend_pc     <= 32'h0;
      pend_vld    <= 1'b0;
      req_held    <= 1'b0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      req_held    <= held_now;
      outstanding <= outstanding_nxt;

      // A still-held request belongs to the old stream, so it is counted now.
      if (redirect)
        discard_cnt <= outstanding_nxt + CW'(held_now);
      else if (inst_sram_data_ok && (discard_cnt != '0))
        discard_cnt <= discard_cnt - CW'(1);

      // The held address must stay stable, so a redirect during a hold is parked.
      if (br.taken) begin
        if (held_now) begin
          pend_vld <= 1'b1;
          pend_pc  <= br.target;
        end else begin
          fetch_pc <= br.target;
          pend_vld <= 1'b0;
        end
      end else if (accept) begin
        if (pend_vld) begin
          fetch_pc <= pend_pc;
          pend_vld <= 1'b0;
        end else begin
          fetch_pc <= next_pc(fetch_pc);
        end
      end
    end
  end

endmodule

// File: tb/tb_stage1_if_prefetch.sv
// Directed and random bench for stage1_if_prefetch with an in-order memory responder.
module tb_stage1_if_prefetch;

  localparam logic [31:0] RESET_PC  = 32'h1C000000;
  localparam int          BUF_DEPTH = 4;
  localparam int          MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allow_in;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_q[$];
  logic [31:0] nxt;
  logic        took, o_req, o_vld;
  logic [31:0] o_pc, o_inst, o_addr;

  stage1_if_prefetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allow_in       (ds_allow_in),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5AF00D;
  endfunction

  function automatic logic [33:0] br_to(input logic [31:0] t);
    return {1'b0, 1'b1, t};
  endfunction

  // One bus cycle starting at a negedge: drive, sample, record the memory handshakes.
  task automatic tick(input logic aok, input logic dok, input logic allow, input logic [33:0] br);
    logic [31:0] dummy;
    ds_allow_in       = allow;
    br_bus            = br;
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok && !reset && (mem_q.size() != 0);
    inst_sram_rdata   = inst_sram_data_ok ? inst_of(mem_q[0]) : 32'h0;
    #1;
    o_req  = inst_sram_req;
    o_addr = inst_sram_addr;
    o_vld  = fs_to_ds_valid;
    took   = fs_to_ds_valid && allow;
    o_pc   = fs_to_ds_bus[31:0];
    o_inst = fs_to_ds_bus[63:32];
    if (inst_sram_data_ok) dummy = mem_q.pop_front();
    if (o_req && aok) mem_q.push_back(o_addr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, '0);
      if (i > 0) begin
        checks++;
        if (o_req !== 1'b0 || o_vld !== 1'b0) begin
          errors++; $display("FAIL reset_outputs: req=%b valid=%b expected 0 0", o_req, o_vld);
        end
        checks++;
        if (o_addr !== RESET_PC) begin
          errors++; $display("FAIL reset_pc: got %h expected %h", o_addr, RESET_PC);
        end
      end
    end
    checks++;
    if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'b10 || inst_sram_wstrb !== 4'h0 || inst_sram_wdata !== 32'h0) begin
      errors++; $display("FAIL bus_constants: wr=%b size=%b wstrb=%h wdata=%h", inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
  endtask

  task automatic test_stream();
    int first = -1;
    int ntake = 0;
    reset = 1'b0;
    nxt   = RESET_PC;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b1, '0);
      if (i == 0) begin
        checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
          errors++; $display("FAIL first_req: req=%b addr=%h expected 1 %h", o_req, o_addr, RESET_PC);
        end
      end
      if (took) begin
        if (first < 0) first = i;
        ntake++;
        checks++;
        if (o_pc !== nxt || o_inst !== inst_of(nxt)) begin
          errors++; $display("FAIL stream_word: pc=%h inst=%h expected %h %h", o_pc, o_inst, nxt, inst_of(nxt));
        end
        nxt += 32'd4;
      end
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL startup_latency: got %0d expected 2", first); end
    checks++;
    if (ntake != 8) begin errors++; $display("FAIL stream_rate: got %0d expected 8", ntake); end
  endtask

  task automatic test_stall();
    int ntake = 0;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (o_req !== 1'b0 || o_vld !== 1'b1 || mem_q.size() != 0) begin
      errors++; $display("FAIL stall_full: req=%b valid=%b inflight=%0d expected 0 1 0", o_req, o_vld, mem_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, '0);
      if (took) begin
        ntake++;
        checks++;
        if (o_pc !== nxt) begin errors++; $display("FAIL stall_order: got %h expected %h", o_pc, nxt); end
        nxt += 32'd4;
      end
    end
    checks++;
    if (ntake != BUF_DEPTH) begin errors++; $display("FAIL stall_depth: got %0d expected %0d", ntake, BUF_DEPTH); end
  endtask

  task automatic test_held_redirect();
    logic [31:0] a;
    int ntake = 0;
    a = nxt;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b1, (i == 1) ? br_to(32'h1C000100) : 34'h0);
      checks++;
      if (o_req !== 1'b1 || o_addr !== a) begin
        errors++; $display("FAIL held_addr: req=%b addr=%h expected 1 %h", o_req, o_addr, a);
      end
    end
    nxt = 32'h1C000100;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b1, '0);
      if (i < 2) begin
        checks++;
        if (o_req !== 1'b1 || o_addr !== ((i == 0) ? a : 32'h1C000100)) begin
          errors++; $display("FAIL held_then_target: step %0d req=%b addr=%h", i, o_req, o_addr);
        end
      end
      if (took) begin
        ntake++;
        checks++;
        if (o_pc !== nxt) begin errors++; $display("FAIL held_redirect_pc: got %h expected %h", o_pc, nxt); end
        nxt += 32'd4;
      end
    end
    checks++;
    if (ntake == 0) begin errors++; $display("FAIL held_redirect_progress: got 0 words expected >0"); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, '0);
      if (took) begin
        checks++;
        if (o_pc !== nxt) begin errors++; $display("FAIL drain_order: got %h expected %h", o_pc, nxt); end
        nxt += 32'd4;
      end
    end
  endtask

  task automatic test_two_outstanding();
    int ntake = 0;
    test_drain();
    tick(1'b1, 1'b0, 1'b1, '0);
    tick(1'b1, 1'b0, 1'b1, '0);
    checks++;
    if (o_addr !== nxt + 32'd4) begin errors++; $display("FAIL second_issue: got %h expected %h", o_addr, nxt + 32'd4); end
    tick(1'b1, 1'b0, 1'b1, br_to(32'h1C000200));
    checks++;
    if (o_req !== 1'b0 || mem_q.size() != 2) begin
      errors++; $display("FAIL outstanding_limit: req=%b inflight=%0d expected 0 2", o_req, mem_q.size());
    end
    nxt = 32'h1C000200;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b1, '0);
      if (took) begin
        ntake++;
        checks++;
        if (o_pc !== nxt) begin errors++; $display("FAIL two_out_redirect: got %h expected %h", o_pc, nxt); end
        nxt += 32'd4;
      end
    end
    checks++;
    if (ntake == 0) begin errors++; $display("FAIL two_out_progress: got 0 words expected >0"); end
  endtask

  task automatic test_same_cycle_response();
    int ntake = 0;
    test_drain();
    tick(1'b1, 1'b0, 1'b1, '0);
    tick(1'b1, 1'b0, 1'b1, '0);
    tick(1'b0, 1'b1, 1'b1, br_to(32'h1C000300));
    checks++;
    if (o_vld !== 1'b0 || mem_q.size() != 1) begin
      errors++; $display("FAIL same_cycle_branch: valid=%b inflight=%0d expected 0 1", o_vld, mem_q.size());
    end
    nxt = 32'h1C000300;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b1, '0);
      if (took) begin
        ntake++;
        checks++;
        if (o_pc !== nxt) begin errors++; $display("FAIL same_cycle_pc: got %h expected %h", o_pc, nxt); end
        nxt += 32'd4;
      end
    end
    checks++;
    if (ntake == 0) begin errors++; $display("FAIL same_cycle_progress: got 0 words expected >0"); end
  endtask

  task automatic test_cancel();
    int ntake = 0;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL cancel_setup: req=%b expected 0", o_req); end
    tick(1'b0, 1'b1, 1'b0, {1'b1, 1'b0, 32'hFFFFFFFC});
    tick(1'b0, 1'b1, 1'b1, '0);
    checks++;
    if (o_vld !== 1'b0 || o_req !== 1'b1 || o_addr !== nxt + 32'd16) begin
      errors++; $display("FAIL cancel_flush: valid=%b req=%b addr=%h expected 0 1 %h", o_vld, o_req, o_addr, nxt + 32'd16);
    end
    nxt += 32'd16;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b1, '0);
      if (took) begin
        ntake++;
        checks++;
        if (o_pc !== nxt) begin errors++; $display("FAIL cancel_resume: got %h expected %h", o_pc, nxt); end
        nxt += 32'd4;
      end
    end
    checks++;
    if (ntake == 0) begin errors++; $display("FAIL cancel_progress: got 0 words expected >0"); end
  endtask

  task automatic test_random();
    int          ntake = 0;
    logic        br_now;
    logic [31:0] tgt;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 1'b1;
        mem_q.delete();
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        nxt   = RESET_PC;
      end
      br_now = ($urandom_range(0, 19) == 0);
      tgt    = 32'h1C001000 + (32'($urandom_range(0, 1023)) << 2);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           br_now ? br_to(tgt) : 34'h0);
      if (took) begin
        ntake++;
        checks++;
        if (o_pc !== nxt || o_inst !== inst_of(nxt)) begin
          errors++; $display("FAIL random_stream: cycle %0d pc=%h inst=%h expected %h %h", i, o_pc, o_inst, nxt, inst_of(nxt));
        end
        nxt += 32'd4;
      end
      if (br_now) begin
        checks++;
        if (o_vld !== 1'b0) begin errors++; $display("FAIL random_branch_valid: got %b expected 0", o_vld); end
        nxt = tgt;
      end
      checks++;
      if (mem_q.size() > MAX_OUT) begin
        errors++; $display("FAIL random_outstanding: got %0d expected <=%0d", mem_q.size(), MAX_OUT);
      end
    end
    checks++;
    if (ntake < 300) begin errors++; $display("FAIL random_progress: got %0d words expected >=300", ntake); end
  endtask

  initial begin
    reset             = 1'b1;
    ds_allow_in       = 1'b0;
    br_bus            = '0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_held_redirect();
    test_two_outstanding();
    test_same_cycle_response();
    test_cancel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
